// File: rtl/quad_speed_ctrl_pkg.sv
// Shared types and helpers for the quadrature speed controller:
// FSM encoding, datapath widths and a signed clamp.
package quad_speed_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_PRIME, ST_WAIT, ST_SAMPLE, ST_ERR, ST_INTEG, ST_UPDATE
  } state_t;

  localparam int VEL_W  = 16;
  localparam int INT_W  = 18;
  localparam int CALC_W = 20;

  function automatic logic signed [CALC_W-1:0] clamp_s(
    input logic signed [CALC_W-1:0] v,
    input logic signed [CALC_W-1:0] lo,
    input logic signed [CALC_W-1:0] hi
  );
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/quad_speed_ctrl_pwm_gen.sv
// Free-running PWM with a shadow-loaded duty/direction pair.
// New values are only taken at counter zero so a period is never cut short.
module pwm_gen
  import quad_speed_ctrl_pkg::*;
#(
  parameter int DUTY_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic [DUTY_W-1:0] i_duty_sh,
  input  logic              i_dir_sh,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_dir,
  output logic              o_pwm
);
  logic [DUTY_W-1:0] r_cnt;
  logic [DUTY_W-1:0] r_duty;
  logic              r_dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_dir  <= 1'b0;
    end else begin
      r_cnt <= r_cnt + DUTY_W'(1);
      // Disable overrides the period boundary so the bridge goes quiet at once.
      if (i_clear) begin
        r_duty <= '0;
        r_dir  <= 1'b0;
      end else if (r_cnt == '0) begin
        r_duty <= i_duty_sh;
        r_dir  <= i_dir_sh;
      end
    end
  end

  assign o_duty = r_duty;
  assign o_dir  = r_dir;
  assign o_pwm  = (r_cnt < r_duty);
endmodule

// File: rtl/quad_speed_ctrl.sv
// Closed-loop speed controller: schedules position samples, derives a wrap-aware
// velocity, runs a shift-gain PI update and drives a PWM/direction pair.
module quad_speed_ctrl
  import quad_speed_ctrl_pkg::*;
#(
  parameter int CLK_DIV        = 131072,
  parameter int COUNTS_PER_REV = 1497,
  parameter int KP_SHIFT       = 2,
  parameter int KI_SHIFT       = 3,
  parameter int INT_LIM        = 8191,
  parameter int DUTY_W         = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic signed [VEL_W-1:0] i_setpoint,
  input  logic [15:0]             i_pos,
  output logic                    o_sample_tick,
  output logic signed [VEL_W-1:0] o_meas_vel,
  output logic [DUTY_W-1:0]       o_duty,
  output logic                    o_dir,
  output logic                    o_pwm,
  output logic                    o_sat,
  output logic                    o_busy,
  output state_t                  o_dbg_state,
  output logic signed [INT_W-1:0] o_dbg_integ,
  output logic [DUTY_W-1:0]       o_dbg_duty_sh,
  output logic                    o_dbg_dir_sh
);
  localparam int D_W   = VEL_W + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]         DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic signed [D_W-1:0]    MOD_S    = D_W'(COUNTS_PER_REV);
  localparam logic signed [D_W-1:0]    HALF_S   = D_W'(COUNTS_PER_REV / 2);
  localparam logic signed [CALC_W-1:0] ERR_HI   = CALC_W'(32767);
  localparam logic signed [CALC_W-1:0] ERR_LO   = -CALC_W'(32768);
  localparam logic signed [CALC_W-1:0] LIM_S    = CALC_W'(INT_LIM);
  localparam logic signed [CALC_W-1:0] DUTY_MAX = CALC_W'((1 << DUTY_W) - 1);

  state_t                  r_state, w_next;
  logic [DIV_W-1:0]        r_div;
  logic                    w_term;
  logic [15:0]             r_pos_in, r_pos_prev, r_pos_cur;
  logic                    r_tick;
  logic signed [VEL_W-1:0] r_meas, r_err;
  logic signed [INT_W-1:0] r_integ;
  logic                    r_sat_err, r_sat_int, r_sat;
  logic [DUTY_W-1:0]       r_duty_sh;
  logic                    r_dir_sh;
  logic signed [D_W-1:0]   w_d, w_d_wrap;
  logic signed [CALC_W-1:0] w_err_raw, w_err_c, w_err_x, w_integ_x;
  logic signed [CALC_W-1:0] w_int_sum, w_int_c, w_u, w_u_c, w_u_mag;
  logic                    w_unused;

  assign w_term = (r_div == DIV_LAST);

  always_comb begin
    w_next = r_state;
    if (!i_en) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_next = ST_PRIME;
        ST_PRIME:  if (w_term) w_next = ST_WAIT;
        ST_WAIT:   if (w_term) w_next = ST_SAMPLE;
        ST_SAMPLE: w_next = ST_ERR;
        ST_ERR:    w_next = ST_INTEG;
        ST_INTEG:  w_next = ST_UPDATE;
        ST_UPDATE: w_next = ST_WAIT;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    // A step larger than half a revolution is the short way round the wrap.
    w_d      = D_W'(r_pos_cur) - D_W'(r_pos_prev);
    w_d_wrap = w_d;
    if (w_d > HALF_S)       w_d_wrap = w_d - MOD_S;
    else if (w_d < -HALF_S) w_d_wrap = w_d + MOD_S;
    w_err_raw = CALC_W'(i_setpoint) - CALC_W'(r_meas);
    w_err_c   = clamp_s(w_err_raw, ERR_LO, ERR_HI);
    w_err_x   = CALC_W'(r_err);
    w_integ_x = CALC_W'(r_integ);
    w_int_sum = w_integ_x + w_err_x;
    w_int_c   = clamp_s(w_int_sum, -LIM_S, LIM_S);
    w_u       = (w_err_x <<< KP_SHIFT) + (w_integ_x >>> KI_SHIFT);
    w_u_c     = clamp_s(w_u, -DUTY_MAX, DUTY_MAX);
    w_u_mag   = w_u_c[CALC_W-1] ? -w_u_c : w_u_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_div      <= '0;
      r_pos_in   <= '0;
      r_pos_prev <= '0;
      r_pos_cur  <= '0;
      r_tick     <= 1'b0;
      r_meas     <= '0;
      r_err      <= '0;
      r_integ    <= '0;
      r_sat_err  <= 1'b0;
      r_sat_int  <= 1'b0;
      r_sat      <= 1'b0;
      r_duty_sh  <= '0;
      r_dir_sh   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_pos_in <= i_pos;
      r_tick   <= 1'b0;
      if (!i_en) begin
        r_div     <= '0;
        r_integ   <= '0;
        r_sat     <= 1'b0;
        r_duty_sh <= '0;
        r_dir_sh  <= 1'b0;
      end else begin
        // The divider free-runs through the compute states so samples never drift.
        r_div <= (r_state == ST_IDLE || w_term) ? '0 : r_div + DIV_W'(1);
        case (r_state)
          ST_PRIME: if (w_term) begin
            r_tick     <= 1'b1;
            r_pos_prev <= r_pos_in;
            r_pos_cur  <= r_pos_in;
          end
          ST_WAIT: if (w_term) begin
            r_tick     <= 1'b1;
            r_pos_prev <= r_pos_cur;
            r_pos_cur  <= r_pos_in;
          end
          ST_SAMPLE: r_meas <= w_d_wrap[VEL_W-1:0];
          ST_ERR: begin
            r_err     <= w_err_c[VEL_W-1:0];
            r_sat_err <= (w_err_c != w_err_raw);
          end
          ST_INTEG: begin
            r_integ   <= w_int_c[INT_W-1:0];
            r_sat_int <= (w_int_c != w_int_sum);
          end
          ST_UPDATE: begin
            r_duty_sh <= w_u_mag[DUTY_W-1:0];
            r_dir_sh  <= ~w_u_c[CALC_W-1];
            r_sat     <= r_sat_err | r_sat_int | (w_u_c != w_u);
          end
          default: ;
        endcase
      end
    end
  end

  pwm_gen #(.DUTY_W(DUTY_W)) u_pwm (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (~i_en),
    .i_duty_sh (r_duty_sh),
    .i_dir_sh  (r_dir_sh),
    .o_duty    (o_duty),
    .o_dir     (o_dir),
    .o_pwm     (o_pwm)
  );

  assign o_sample_tick = r_tick;
  assign o_meas_vel    = r_meas;
  assign o_sat         = r_sat;
  assign o_busy        = (r_state == ST_SAMPLE) || (r_state == ST_ERR) ||
                         (r_state == ST_INTEG)  || (r_state == ST_UPDATE);
  assign o_dbg_state   = r_state;
  assign o_dbg_integ   = r_integ;
  assign o_dbg_duty_sh = r_duty_sh;
  assign o_dbg_dir_sh  = r_dir_sh;
  assign w_unused      = ^{w_d_wrap[D_W-1], w_u_mag[CALC_W-1:DUTY_W]};
endmodule

// File: tb/tb_quad_speed_ctrl.sv
// Directed bench for quad_speed_ctrl with a fast sample divider and
// hand-computed expectations for velocity, PI update and PWM behaviour.
module tb_quad_speed_ctrl;
  import quad_speed_ctrl_pkg::*;

  localparam int CLK_DIV = 16;
  localparam int DUTY_W  = 10;
  localparam int MOD     = 1497;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic signed [15:0] setpoint;
  logic [15:0]        pos;
  logic               sample_tick;
  logic signed [15:0] meas_vel;
  logic [DUTY_W-1:0]  duty;
  logic               dir;
  logic               pwm;
  logic               sat;
  logic               busy;
  state_t             dbg_state;
  logic signed [17:0] dbg_integ;
  logic [DUTY_W-1:0]  dbg_duty_sh;
  logic               dbg_dir_sh;

  int n_checks = 0;
  int n_errors = 0;
  int cur_pos  = 0;

  always #5 clk = ~clk;

  quad_speed_ctrl #(.CLK_DIV(CLK_DIV), .DUTY_W(DUTY_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_en          (en),
    .i_setpoint    (setpoint),
    .i_pos         (pos),
    .o_sample_tick (sample_tick),
    .o_meas_vel    (meas_vel),
    .o_duty        (duty),
    .o_dir         (dir),
    .o_pwm         (pwm),
    .o_sat         (sat),
    .o_busy        (busy),
    .o_dbg_state   (dbg_state),
    .o_dbg_integ   (dbg_integ),
    .o_dbg_duty_sh (dbg_duty_sh),
    .o_dbg_dir_sh  (dbg_dir_sh)
  );

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input string tag, input logic exp_busy);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (sample_tick !== 1'b1 && k < 4 * CLK_DIV);
    check_val({tag, "_tick"}, sample_tick, 1);
    check_val({tag, "_busy"}, busy, exp_busy);
  endtask

  // Move the decoder position, then let one full update complete.
  task automatic sample(input int dpos);
    cur_pos = (cur_pos + dpos + MOD) % MOD;
    pos = 16'(cur_pos);
    wait_tick("smp", 1'b1);
    step(4);
  endtask

  task automatic run_samples(input int n, input int dpos);
    for (int i = 0; i < n; i++) sample(dpos);
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_tick"}, sample_tick, 0);
    check_val({tag, "_meas"}, meas_vel, 0);
    check_val({tag, "_duty"}, duty, 0);
    check_val({tag, "_dir"}, dir, 0);
    check_val({tag, "_pwm"}, pwm, 0);
    check_val({tag, "_sat"}, sat, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_state"}, dbg_state, ST_IDLE);
    check_val({tag, "_integ"}, dbg_integ, 0);
    check_val({tag, "_dsh"}, dbg_duty_sh, 0);
  endtask

  task automatic restart(input int sp, input int p);
    en = 1'b0;
    step(2);
    check_val("restart_idle", dbg_state, ST_IDLE);
    setpoint = 16'(sp);
    cur_pos = p;
    pos = 16'(p);
    en = 1'b1;
    wait_tick("prime", 1'b0);
    step(4);
    check_val("prime_no_update", dbg_duty_sh, 0);
  endtask

  initial begin
    int hi;
    int ticks;
    int exp_int;
    int wp[3]   = '{3, 5, 1492};
    int wv[3]   = '{10, 2, -10};
    int rduty[4] = '{83, 85, 88, 90};

    rst = 1'b1; en = 1'b0; setpoint = '0; pos = '0;
    step(3);
    check_cleared("reset");
    rst = 1'b0;
    ticks = 0;
    repeat (3 * CLK_DIV) begin
      @(negedge clk);
      if (sample_tick === 1'b1) ticks++;
    end
    check_val("idle_silent", ticks, 0);

    // Steady: velocity matches setpoint, zero error, no drive
    restart(10, 100);
    for (int i = 0; i < 4; i++) begin
      sample(10);
      check_val("steady_meas", meas_vel, 10);
      check_val("steady_dsh", dbg_duty_sh, 0);
      check_val("steady_dir", dbg_dir_sh, 1);
      check_val("steady_sat", sat, 0);
      check_val("steady_integ", dbg_integ, 0);
    end

    // Position wrap in both directions
    restart(10, 1490);
    for (int i = 0; i < 3; i++) begin
      cur_pos = wp[i];
      sample(0);
      check_val("wrap_meas", meas_vel, wv[i]);
    end

    // Reverse drive with a stalled shaft
    restart(-20, 700);
    for (int k = 1; k <= 4; k++) begin
      sample(0);
      check_val("rev_meas", meas_vel, 0);
      check_val("rev_integ", dbg_integ, -20 * k);
      check_val("rev_dsh", dbg_duty_sh, rduty[k-1]);
      check_val("rev_dir", dbg_dir_sh, 0);
      check_val("rev_sat", sat, 0);
    end
    run_samples(140, -20);
    check_val("rev_track_meas", meas_vel, -20);
    check_val("rev_track_integ", dbg_integ, -80);
    check_val("rev_duty", duty, 10);
    check_val("rev_odir", dir, 0);
    hi = 0;
    fork
      run_samples(70, -20);
      begin
        repeat (1024) begin
          @(negedge clk);
          hi += int'(pwm);
        end
      end
    join
    check_val("rev_pwm_high", hi, 10);

    // Saturation: large setpoint, shaft creeping forward
    restart(1000, 200);
    for (int k = 1; k <= 10; k++) begin
      sample(3);
      exp_int = (997 * k > 8191) ? 8191 : 997 * k;
      check_val("sat_integ", dbg_integ, exp_int);
      check_val("sat_dsh", dbg_duty_sh, 1023);
      check_val("sat_flag", sat, 1);
    end
    run_samples(130, 3);
    check_val("sat_duty", duty, 1023);
    check_val("sat_odir", dir, 1);
    check_val("sat_integ_hold", dbg_integ, 8191);
    hi = 0;
    fork
      run_samples(70, 3);
      begin
        repeat (1024) begin
          @(negedge clk);
          hi += int'(pwm);
        end
      end
    join
    check_val("sat_pwm_high", hi, 1023);
    check_val("sat_flag_hold", sat, 1);

    // Enable drop in the middle of the integrator step
    cur_pos = (cur_pos + 3) % MOD;
    pos = 16'(cur_pos);
    wait_tick("drop", 1'b1);
    step(2);
    check_val("drop_in_integ", dbg_state, ST_INTEG);
    en = 1'b0;
    step(1);
    check_val("drop_state", dbg_state, ST_IDLE);
    check_val("drop_pwm", pwm, 0);
    check_val("drop_duty", duty, 0);
    check_val("drop_integ", dbg_integ, 0);
    check_val("drop_busy", busy, 0);
    check_val("drop_dsh", dbg_duty_sh, 0);
    check_val("drop_meas_hold", meas_vel, 3);
    step(3);
    cur_pos = (cur_pos + 3) % MOD;
    pos = 16'(cur_pos);
    en = 1'b1;
    wait_tick("reprime", 1'b0);
    check_val("reprime_state", dbg_state, ST_WAIT);
    step(4);
    check_val("reprime_dsh", dbg_duty_sh, 0);
    check_val("reprime_integ", dbg_integ, 0);
    sample(3);
    check_val("reen_meas", meas_vel, 3);
    check_val("reen_integ", dbg_integ, 997);
    check_val("reen_dsh", dbg_duty_sh, 1023);

    // Asynchronous reset during the output update
    cur_pos = (cur_pos + 3) % MOD;
    pos = 16'(cur_pos);
    wait_tick("rstupd", 1'b1);
    step(3);
    check_val("rst_in_update", dbg_state, ST_UPDATE);
    en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_cleared("async_rst");
    step(2);
    rst = 1'b0;
    ticks = 0;
    repeat (5 * CLK_DIV) begin
      @(negedge clk);
      if (sample_tick === 1'b1) ticks++;
    end
    check_val("post_rst_silent", ticks, 0);
    check_val("post_rst_idle", dbg_state, ST_IDLE);
    en = 1'b1;
    wait_tick("post_rst_prime", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
